// File: rtl/axi_pkg.sv
// Shared AXI definitions for the burst RAM: burst/response codes, FSM state types
// and the transfer-size legality helper.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    // A beat of 2^size bytes must fit inside one data word.
    function automatic logic size_legal(input logic [2:0] size, input int data_width);
        return (8 << size) <= data_width;
    endfunction

endpackage

// File: rtl/axi_burst_ram_if.sv
// AXI4 read/write channel bundle between an interconnect master and the burst RAM slave.
interface axi_burst_ram_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;

    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH/8-1:0]  wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;

    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; arithmetic wraps
// modulo 2^ADDRESS_WIDTH.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [7:0]               len_i,
    input  logic [2:0]               size_i,
    input  logic [1:0]               burst_i,
    output logic [ADDRESS_WIDTH-1:0] next_addr_o
);
    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] incr;
    logic [ADDRESS_WIDTH-1:0] span;
    logic [ADDRESS_WIDTH-1:0] mask;

    always_comb begin
        step = ADDRESS_WIDTH'(1) << size_i;
        incr = addr_i + step;
        // Wrap window is the whole burst footprint; upper bits stay at the aligned base.
        span = ADDRESS_WIDTH'({1'b0, len_i} + 9'd1) << size_i;
        mask = span - ADDRESS_WIDTH'(1);
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~mask) | (incr & mask);
            default:     next_addr_o = incr;
        endcase
    end
endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 burst scratchpad RAM, independent read/write FSMs, one outstanding burst each.
// WRAP bursts are only legal when AXI_WRAP_BURST_EN is defined.
module axi_burst_ram
    import axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 64
) (
    input  logic             aclk,
    input  logic             areset,
    axi_burst_ram_if.slave   axi_s
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(NBYTES);
    localparam int IDXW   = $clog2(DEPTH);
`ifdef AXI_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDRESS_WIDTH-1:0] a);
        logic [ADDRESS_WIDTH-1:0] s;
        s = a >> OFFS;
        return s[IDXW-1:0];
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic e;
        e = !size_legal(size, DATA_WIDTH);
        if (burst == 2'b11)
            e = 1'b1;
        if (burst == BURST_WRAP &&
            (!WRAP_EN || !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)))
            e = 1'b1;
        return e;
    endfunction

    // ---------------- read channel ----------------
    r_state_t                 r_state_q, r_state_d;
    logic [ADDRESS_WIDTH-1:0] r_addr_q, r_addr_d, r_next_addr;
    logic [7:0]               r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]               r_size_q, r_size_d;
    logic [1:0]               r_burst_q, r_burst_d;
    logic                     r_err_q, r_err_d;
    logic                     r_last;

    axi_burst_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_rd_addr (
        .addr_i     (r_addr_q),
        .len_i      (r_len_q),
        .size_i     (r_size_q),
        .burst_i    (r_burst_q),
        .next_addr_o(r_next_addr)
    );

    assign r_last = (r_cnt_q == r_len_q);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi_s.arvalid) begin
                    r_addr_d  = axi_s.araddr;
                    r_len_d   = axi_s.arlen;
                    r_size_d  = axi_s.arsize;
                    r_burst_d = axi_s.arburst;
                    r_cnt_d   = '0;
                    r_err_d   = burst_err(axi_s.arlen, axi_s.arsize, axi_s.arburst);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_s.rready) begin
                    r_addr_d = r_next_addr;
                    r_cnt_d  = r_cnt_q + 8'd1;
                    if (r_last)
                        r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign axi_s.arready = (r_state_q == R_IDLE);
    assign axi_s.rvalid  = (r_state_q == R_DATA);
    assign axi_s.rlast   = axi_s.rvalid && r_last;
    assign axi_s.rresp   = (axi_s.rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    // Asynchronous array read: a same-cycle write lands after this beat is sampled.
    assign axi_s.rdata   = (axi_s.rvalid && !r_err_q) ? mem[word_idx(r_addr_q)] : '0;

    // ---------------- write channel ----------------
    w_state_t                 w_state_q, w_state_d;
    logic [ADDRESS_WIDTH-1:0] w_addr_q, w_addr_d, w_next_addr;
    logic [7:0]               w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]               w_size_q, w_size_d;
    logic [1:0]               w_burst_q, w_burst_d;
    logic                     w_err_q, w_err_d;
    logic                     w_beat, w_last_exp, w_last_bad, mem_we;
    logic [DATA_WIDTH-1:0]    wmask;

    axi_burst_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_wr_addr (
        .addr_i     (w_addr_q),
        .len_i      (w_len_q),
        .size_i     (w_size_q),
        .burst_i    (w_burst_q),
        .next_addr_o(w_next_addr)
    );

    assign w_beat     = (w_state_q == W_DATA) && axi_s.wvalid;
    assign w_last_exp = (w_cnt_q == w_len_q);
    assign w_last_bad = (axi_s.wlast != w_last_exp);
    // Any error so far, including this beat's wlast mismatch, drops the write.
    assign mem_we     = w_beat && !w_err_q && !w_last_bad;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (axi_s.awvalid) begin
                    w_addr_d  = axi_s.awaddr;
                    w_len_d   = axi_s.awlen;
                    w_size_d  = axi_s.awsize;
                    w_burst_d = axi_s.awburst;
                    w_cnt_d   = '0;
                    w_err_d   = burst_err(axi_s.awlen, axi_s.awsize, axi_s.awburst);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_s.wvalid) begin
                    w_err_d = w_err_q | w_last_bad;
                    if (w_last_exp) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_addr_d = w_next_addr;
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (axi_s.bready)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign axi_s.awready = (w_state_q == W_IDLE);
    assign axi_s.wready  = (w_state_q == W_DATA);
    assign axi_s.bvalid  = (w_state_q == W_RESP);
    assign axi_s.bresp   = (axi_s.bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_wmask
        assign wmask[gi*8 +: 8] = {8{axi_s.wstrb[gi]}};
    end

    always_ff @(posedge aclk) begin
        if (mem_we)
            mem[word_idx(w_addr_q)] <= (mem[word_idx(w_addr_q)] & ~wmask) |
                                       (axi_s.wdata & wmask);
    end

endmodule

// File: tb/tb_axi_burst_ram.sv
// Scoreboard bench for axi_burst_ram: stimulus tasks queue expected R beats / B responses,
// a negedge monitor pops and compares them. Honours AXI_WRAP_BURST_EN for the WRAP case.
module tb_axi_burst_ram;
    import axi_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    logic aclk = 1'b0;
    logic areset;

    axi_burst_ram_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_burst_ram #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .aclk  (aclk),
        .areset(areset),
        .axi_s (bus)
    );

    always #5 aclk = ~aclk;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    int          checks   = 0;
    int          failures = 0;
    logic        hold_valid = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;
    rexp_t       mon_r;
    logic [1:0]  mon_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout or unexpected event", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge aclk) begin
        if (hold_valid) begin
            check("r_stall_valid", 64'(bus.rvalid), 64'd1);
            check("r_stall_data", 64'(bus.rdata), 64'(hold_data));
            check("r_stall_last", 64'(bus.rlast), 64'(hold_last));
        end
        hold_valid = bus.rvalid && !bus.rready && !areset;
        hold_data  = bus.rdata;
        hold_last  = bus.rlast;
        if (bus.rvalid && bus.rready && !areset) begin
            if (rq.size() == 0) begin
                fail_now("r_unexpected_beat");
            end else begin
                mon_r = rq.pop_front();
                $display("R beat data=0x%08h resp=%0d last=%0b", bus.rdata, bus.rresp, bus.rlast);
                check("r_data", 64'(bus.rdata), 64'(mon_r.data));
                check("r_resp", 64'(bus.rresp), 64'(mon_r.resp));
                check("r_last", 64'(bus.rlast), 64'(mon_r.last));
            end
        end
        if (bus.bvalid && bus.bready && !areset) begin
            if (bq.size() == 0) begin
                fail_now("b_unexpected");
            end else begin
                mon_b = bq.pop_front();
                $display("B resp=%0d", bus.bresp);
                check("b_resp", 64'(bus.bresp), 64'(mon_b));
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
        rexp_t e;
        e.data = data;
        e.resp = resp;
        e.last = last;
        rq.push_back(e);
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [31:0] base, input logic [31:0] step,
                               input logic [3:0] strb, input int bad_idx, input logic [1:0] exp_resp);
        bit ok;
        $display("WRITE addr=0x%02h len=%0d size=%0d burst=%0d", addr, len, size, burst);
        bq.push_back(exp_resp);
        @(posedge aclk); #1;
        bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (bus.awready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("aw_handshake");
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = base + step * 32'(i);
            bus.wstrb  = strb;
            bus.wlast  = (bad_idx >= 0) ? (i == bad_idx) : (i == int'(len));
            bus.wvalid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge aclk);
                if (bus.wready) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("w_beat_accept");
            @(posedge aclk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (bq.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("b_wait");
    endtask

    task automatic ar_handshake(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
        bit ok;
        $display("READ addr=0x%02h len=%0d size=%0d burst=%0d", addr, len, size, burst);
        @(posedge aclk); #1;
        bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (bus.arready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("ar_handshake");
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input bit toggle);
        int got;
        ar_handshake(addr, len, size, burst);
        got = 0;
        for (int k = 0; k < 200 && got <= int'(len); k++) begin
            bus.rready = toggle ? (k % 2 == 0) : 1'b1;
            @(negedge aclk);
            if (bus.rvalid && bus.rready) begin
                got++;
                if (got == int'(len) + 1)
                    check("arready_low_on_last", 64'(bus.arready), 64'd0);
            end
            @(posedge aclk); #1;
        end
        bus.rready = 1'b0;
        if (got <= int'(len)) fail_now("r_beats");
        check("arready_after_last", 64'(bus.arready), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int got;
        areset = 1'b1;
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        #3;
        check("rst_arready", 64'(bus.arready), 64'd1);
        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_wready", 64'(bus.wready), 64'd0);
        check("rst_bvalid", 64'(bus.bvalid), 64'd0);
        check("rst_rlast", 64'(bus.rlast), 64'd0);
        check("rst_rresp", 64'(bus.rresp), 64'd0);
        check("rst_bresp", 64'(bus.bresp), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        #24 areset = 1'b0;

        // INCR write/read words 4..7
        write_burst(8'h10, 8'd3, 3'd2, BURST_INCR, 32'hA0, 32'd1, 4'hF, -1, OK);
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OK, i == 3);
        read_burst(8'h10, 8'd3, 3'd2, BURST_INCR, 1'b0);

        // six-beat read with rready toggling
        write_burst(8'h20, 8'd1, 3'd2, BURST_INCR, 32'hB0, 32'd1, 4'hF, -1, OK);
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OK, 1'b0);
        push_r(32'hB0, OK, 1'b0);
        push_r(32'hB1, OK, 1'b1);
        read_burst(8'h10, 8'd5, 3'd2, BURST_INCR, 1'b1);

        // FIXED write leaves last beat in word 1
        write_burst(8'h04, 8'd2, 3'd2, BURST_FIXED, 32'd1, 32'd1, 4'hF, -1, OK);
        push_r(32'd3, OK, 1'b1);
        read_burst(8'h04, 8'd0, 3'd2, BURST_INCR, 1'b0);

        // partial strobe
        write_burst(8'h08, 8'd0, 3'd2, BURST_INCR, 32'd0, 32'd0, 4'hF, -1, OK);
        write_burst(8'h08, 8'd0, 3'd2, BURST_INCR, 32'hFFFF_FFFF, 32'd0, 4'h3, -1, OK);
        push_r(32'h0000_FFFF, OK, 1'b1);
        read_burst(8'h08, 8'd0, 3'd2, BURST_INCR, 1'b0);

        // WRAP read from 0x38 in the 0x30..0x3F window
        write_burst(8'h30, 8'd3, 3'd2, BURST_INCR, 32'hC0, 32'd1, 4'hF, -1, OK);
`ifdef AXI_WRAP_BURST_EN
        push_r(32'hC2, OK, 1'b0);
        push_r(32'hC3, OK, 1'b0);
        push_r(32'hC0, OK, 1'b0);
        push_r(32'hC1, OK, 1'b1);
`else
        for (int i = 0; i < 4; i++) push_r(32'd0, SE, i == 3);
`endif
        read_burst(8'h38, 8'd3, 3'd2, BURST_WRAP, 1'b0);

        // oversize read
        for (int i = 0; i < 4; i++) push_r(32'd0, SE, i == 3);
        read_burst(8'h10, 8'd3, 3'd3, BURST_INCR, 1'b0);

        // early wlast on beat 2: first beat lands, the rest are dropped
        write_burst(8'h50, 8'd3, 3'd2, BURST_INCR, 32'd0, 32'd0, 4'hF, -1, OK);
        write_burst(8'h50, 8'd3, 3'd2, BURST_INCR, 32'hD0, 32'd1, 4'hF, 1, SE);
        push_r(32'hD0, OK, 1'b0);
        push_r(32'd0, OK, 1'b0);
        push_r(32'd0, OK, 1'b0);
        push_r(32'd0, OK, 1'b1);
        read_burst(8'h50, 8'd3, 3'd2, BURST_INCR, 1'b0);

        // WRAP with illegal length, reserved burst type
        write_burst(8'h60, 8'd2, 3'd2, BURST_WRAP, 32'hE0, 32'd1, 4'hF, -1, SE);
        push_r(32'd0, SE, 1'b1);
        read_burst(8'h10, 8'd0, 3'd2, 2'b11, 1'b0);

        // reset in the middle of a six-beat read
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OK, 1'b0);
        push_r(32'hB0, OK, 1'b0);
        push_r(32'hB1, OK, 1'b1);
        ar_handshake(8'h10, 8'd5, 3'd2, BURST_INCR);
        bus.rready = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got < 2; k++) begin
            @(negedge aclk);
            if (bus.rvalid && bus.rready) got++;
            @(posedge aclk); #1;
        end
        if (got < 2) fail_now("reset_pre_beats");
        bus.rready = 1'b0;
        #2 areset = 1'b1;
        #1;
        $display("RESET mid-burst");
        check("abort_rvalid", 64'(bus.rvalid), 64'd0);
        check("abort_arready", 64'(bus.arready), 64'd1);
        check("abort_rlast", 64'(bus.rlast), 64'd0);
        rq.delete();
        #4 areset = 1'b0;
        push_r(32'hA0, OK, 1'b0);
        push_r(32'hA1, OK, 1'b1);
        read_burst(8'h10, 8'd1, 3'd2, BURST_INCR, 1'b0);

        repeat (5) @(posedge aclk);
        #1;
        check("r_queue_drained", 64'(rq.size()), 64'd0);
        check("b_queue_drained", 64'(bq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
